exp_align_pipe: RTL and testbench

Pipelined, parametrised exponent datapath for the FP MAC. Computes the biased product exponent, signed exponent difference, saturating alignment shift and result exponent for three operation modes (FMA, multiply-only, add-only), plus underflow/overflow/zero side flags. It is a 2-stage valid/ready pipeline that sits in front of the significand alignment shifter and carries one operation per cycle.

---
 rtl/exp_align_pipe_if.sv | 32 +++
 rtl/exp_align_pipe.sv | 147 ++++++++++++++
 tb/tb_exp_align_pipe.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/exp_align_pipe_if.sv
// Operation/result handshake bundle for exp_align_pipe.
// master drives operations and out_ready; slave is the pipeline itself.
interface exp_align_pipe_if #(
    parameter int unsigned ex_width = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            mode;
    logic [ex_width-1:0]   Ea;
    logic [ex_width-1:0]   Eb;
    logic [ex_width-1:0]   Ec;
    logic                  ab_zero;
    logic                  c_zero;
    logic                  out_valid;
    logic                  out_ready;
    logic [ex_width+1:0]   shift;
    logic [ex_width+1:0]   sd;
    logic [ex_width+1:0]   max_exp;
    logic                  prod_undf;
    logic                  prod_ovf;
    logic                  shift_sat;

    modport master (
        output in_valid, mode, Ea, Eb, Ec, ab_zero, c_zero, out_ready,
        input  in_ready, out_valid, shift, sd, max_exp, prod_undf, prod_ovf, shift_sat
    );

    modport slave (
        input  in_valid, mode, Ea, Eb, Ec, ab_zero, c_zero, out_ready,
        output in_ready, out_valid, shift, sd, max_exp, prod_undf, prod_ovf, shift_sat
    );
endinterface

// File: rtl/exp_align_pipe.sv
// Two-stage valid/ready exponent datapath for the FP MAC (product exponent, alignment shift).
// Optional shift clamping is enabled with the EXP_ALIGN_SHIFT_SAT_EN macro.
module exp_align_pipe #(
    parameter int unsigned sig_width = 23,
    parameter int unsigned ex_width  = 8,
    parameter int unsigned MAX_SHIFT = 3*sig_width+6
) (
    input  logic             clk,
    input  logic             rst_n,
    exp_align_pipe_if.slave  bus
);
    localparam int unsigned W          = ex_width + 2;
    localparam int unsigned BIAS       = (1 << (ex_width - 1)) - 1;
    localparam int unsigned SHIFT_BIAS = sig_width + 4;
    localparam int unsigned OVF_LIM    = (1 << ex_width) - 1;
    localparam logic [1:0]  MODE_MUL   = 2'b01;
    localparam logic [1:0]  MODE_ADD   = 2'b10;

    if (MAX_SHIFT >= (1 << (ex_width + 1))) begin : g_bad_max_shift
        $error("exp_align_pipe: MAX_SHIFT must be below 2**(ex_width+1)");
    end

    logic                s1_valid;
    logic                s2_valid;
    logic [W-1:0]        s1_eab;
    logic [ex_width-1:0] s1_ec;
    logic [1:0]          s1_mode;
    logic                s1_ab_zero;
    logic                s1_c_zero;
    logic                s1_undf;
    logic                s1_ovf;

    logic                s1_load;
    logic                s2_load;

    // Stage 1: biased product exponent and its range flags
    logic [W-1:0]        eab_c;
    logic                undf_c;
    logic                ovf_c;

    always_comb begin
        eab_c  = W'(bus.Ea) + W'(bus.Eb) - W'(BIAS);
        undf_c = 1'b0;
        ovf_c  = 1'b0;
        if (bus.mode == MODE_ADD) begin
            eab_c = W'(bus.Ea);
        end else begin
            undf_c = eab_c[W-1];
            ovf_c  = !eab_c[W-1] && (eab_c >= W'(OVF_LIM));
        end
    end

    // Stage 2: difference, alignment shift, result exponent and overrides
    logic [W-1:0]        ec_ext;
    logic [W-1:0]        sd_c;
    logic [W-1:0]        raw_c;
    logic [W-1:0]        shift_c;
    logic [W-1:0]        max_c;
    logic                undf2_c;
    logic                ovf2_c;
    logic                sat_c;

    always_comb begin
        ec_ext  = W'(s1_ec);
        sd_c    = s1_eab - ec_ext;
        raw_c   = sd_c + W'(SHIFT_BIAS);
        shift_c = raw_c[W-1] ? '0 : raw_c;
        max_c   = sd_c[W-1] ? ec_ext : s1_eab;
        undf2_c = s1_undf;
        ovf2_c  = s1_ovf;
        sat_c   = 1'b0;
`ifdef EXP_ALIGN_SHIFT_SAT_EN
        if (shift_c > W'(MAX_SHIFT)) begin
            shift_c = W'(MAX_SHIFT);
            sat_c   = 1'b1;
        end
`endif
        if (s1_mode == MODE_MUL) begin
            sd_c    = '0;
            shift_c = '0;
            max_c   = s1_eab;
            sat_c   = 1'b0;
        end else if (s1_ab_zero) begin
            max_c   = ec_ext;
            shift_c = '0;
            undf2_c = 1'b0;
            ovf2_c  = 1'b0;
            sat_c   = 1'b0;
        end else if (s1_c_zero) begin
            max_c   = s1_eab;
            shift_c = W'(MAX_SHIFT);
`ifdef EXP_ALIGN_SHIFT_SAT_EN
            sat_c   = 1'b1;
`endif
        end
    end

    // Each stage advances when the stage after it can take its contents
    assign s2_load       = !s2_valid || bus.out_ready;
    assign s1_load       = !s1_valid || s2_load;
    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            s1_eab        <= '0;
            s1_ec         <= '0;
            s1_mode       <= '0;
            s1_ab_zero    <= 1'b0;
            s1_c_zero     <= 1'b0;
            s1_undf       <= 1'b0;
            s1_ovf        <= 1'b0;
            bus.sd        <= '0;
            bus.shift     <= '0;
            bus.max_exp   <= '0;
            bus.prod_undf <= 1'b0;
            bus.prod_ovf  <= 1'b0;
            bus.shift_sat <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_eab     <= eab_c;
                    s1_ec      <= bus.Ec;
                    s1_mode    <= bus.mode;
                    s1_ab_zero <= bus.ab_zero;
                    s1_c_zero  <= bus.c_zero;
                    s1_undf    <= undf_c;
                    s1_ovf     <= ovf_c;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    bus.sd        <= sd_c;
                    bus.shift     <= shift_c;
                    bus.max_exp   <= max_c;
                    bus.prod_undf <= undf2_c;
                    bus.prod_ovf  <= ovf2_c;
                    bus.shift_sat <= sat_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_exp_align_pipe.sv
// Directed self-checking bench for exp_align_pipe (default parameters, MAX_SHIFT = 75).
// Expected shift/shift_sat follow whether EXP_ALIGN_SHIFT_SAT_EN is defined for the build.
module tb_exp_align_pipe;
    localparam int unsigned EXW = 8;
`ifdef EXP_ALIGN_SHIFT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   sent = 0;
    int   rcv = 0;
    int   cyc = 0;
    bit   acc;

    always #5 clk = ~clk;

    exp_align_pipe_if #(.ex_width(EXW)) bus ();

    exp_align_pipe #(
        .sig_width (23),
        .ex_width  (EXW),
        .MAX_SHIFT (75)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input int ea, input int eb,
                         input int ec, input logic abz, input logic cz);
        bus.in_valid = v;
        bus.mode     = m;
        bus.Ea       = EXW'(ea);
        bus.Eb       = EXW'(eb);
        bus.Ec       = EXW'(ec);
        bus.ab_zero  = abz;
        bus.c_zero   = cz;
    endtask

    // One isolated operation: accept, check 2-cycle latency, check every result field
    task automatic run_op(input string tag, input logic [1:0] m, input int ea, input int eb,
                          input int ec, input logic abz, input logic cz,
                          input int e_sd, input int e_shift, input int e_max,
                          input logic e_undf, input logic e_ovf, input logic e_sat);
        logic [EXW+1:0] sd_w;
        logic [EXW+1:0] sh_w;
        logic [EXW+1:0] mx_w;
        sd_w = (EXW+2)'(e_sd);
        sh_w = (EXW+2)'(e_shift);
        mx_w = (EXW+2)'(e_max);
        @(negedge clk);
        drive(1'b1, m, ea, eb, ec, abz, cz);
        #1 chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b0);
        chk({tag, ".early"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".sd"},        32'(bus.sd),        32'(sd_w));
        chk({tag, ".shift"},     32'(bus.shift),     32'(sh_w));
        chk({tag, ".max_exp"},   32'(bus.max_exp),   32'(mx_w));
        chk({tag, ".undf"},      32'(bus.prod_undf), 32'(e_undf));
        chk({tag, ".ovf"},       32'(bus.prod_ovf),  32'(e_ovf));
        chk({tag, ".sat"},       32'(bus.shift_sat), 32'(e_sat));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.shift",     32'(bus.shift),     32'd0);
        chk("rst.sd",        32'(bus.sd),        32'd0);
        chk("rst.max_exp",   32'(bus.max_exp),   32'd0);
        chk("rst.flags",     32'({bus.prod_undf, bus.prod_ovf, bus.shift_sat}), 32'd0);

        //     tag         mode   Ea   Eb   Ec  abz   cz     sd  shift                max  undf  ovf   sat
        run_op("fma_eq",   2'b00, 127, 127, 127, 1'b0, 1'b0,    0, 27,                127, 1'b0, 1'b0, 1'b0);
        run_op("fma_cbig", 2'b00, 127, 127, 200, 1'b0, 1'b0,  -73, 0,                 200, 1'b0, 1'b0, 1'b0);
        run_op("fma_undf", 2'b00, 10,  10,  0,   1'b0, 1'b0, -107, 0,                 0,   1'b1, 1'b0, 1'b0);
        run_op("fma_ovf",  2'b00, 254, 254, 0,   1'b0, 1'b0,  381, SAT_EN ? 75 : 408, 381, 1'b0, 1'b1, SAT_EN);
        run_op("ovf_edge", 2'b00, 128, 254, 255, 1'b0, 1'b0,    0, 27,                255, 1'b0, 1'b1, 1'b0);
        run_op("ovf_below",2'b00, 127, 254, 254, 1'b0, 1'b0,    0, 27,                254, 1'b0, 1'b0, 1'b0);
        run_op("add",      2'b10, 130, 5,   127, 1'b0, 1'b0,    3, 30,                130, 1'b0, 1'b0, 1'b0);
        run_op("mul",      2'b01, 127, 127, 50,  1'b0, 1'b0,    0, 0,                 127, 1'b0, 1'b0, 1'b0);
        run_op("clamp",    2'b00, 127, 127, 50,  1'b0, 1'b0,   77, SAT_EN ? 75 : 104, 127, 1'b0, 1'b0, SAT_EN);
        run_op("c_zero",   2'b00, 127, 127, 0,   1'b0, 1'b1,  127, 75,                127, 1'b0, 1'b0, SAT_EN);
        run_op("ab_zero",  2'b00, 10,  10,  100, 1'b1, 1'b0, -207, 0,                 100, 1'b0, 1'b0, 1'b0);
        run_op("both_zero",2'b00, 127, 127, 5,   1'b1, 1'b1,  122, 0,                 5,   1'b0, 1'b0, 1'b0);
        run_op("mul_abz",  2'b01, 254, 254, 0,   1'b1, 1'b0,    0, 0,                 381, 1'b0, 1'b1, 1'b0);
        run_op("mode3",    2'b11, 127, 127, 127, 1'b0, 1'b0,    0, 27,                127, 1'b0, 1'b0, 1'b0);

        // Five back-to-back ADD ops (Ea=100+i, Ec=100) with out_ready low in cycles 3..6
        @(negedge clk);
        while (rcv < 5 && cyc < 40) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            drive(sent < 5, 2'b10, 100 + sent, 0, 100, 1'b0, 1'b0);
            #1;
            if (cyc >= 3 && cyc <= 6)
                chk("bp.hold_valid", 32'(bus.out_valid), 32'd1);
            if (bus.out_valid) begin
                chk("bp.max_exp", 32'(bus.max_exp), 32'(100 + rcv));
                chk("bp.sd",      32'(bus.sd),      32'(rcv));
                chk("bp.shift",   32'(bus.shift),   32'(27 + rcv));
            end
            if (sent < 5)
                chk("bp.in_ready", 32'(bus.in_ready), (cyc >= 3 && cyc <= 6) ? 32'd0 : 32'd1);
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) rcv++;
            @(posedge clk);
            if (acc) sent++;
            cyc++;
            @(negedge clk);
        end
        chk("bp.count", 32'(rcv), 32'd5);
        drive(1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;

        // Reset with two operations in flight
        @(negedge clk);
        drive(1'b1, 2'b10, 50, 0, 50, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b10, 51, 0, 50, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b0);
        chk("mid.out_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.rst_valid",   32'(bus.out_valid), 32'd0);
        chk("mid.rst_ready",   32'(bus.in_ready),  32'd1);
        chk("mid.rst_max_exp", 32'(bus.max_exp),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid.discarded", 32'(bus.out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
